instruction_write_arbiter: RTL and testbench
============================================

Name: instruction_write_arbiter

Overview:
- Shares one instruction-memory write port among NUM_REQ requesters, e.g. host loader, debug unit, self-modifying-code path and test injector.
- Each requester uses a valid/ready handshake; accepted writes are grant-fair by round-robin.
- A requester may lock the port for a burst; a timeout guard breaks a stalled lock.
- Output drives the memory's write address/data/enable, registered, one write per cycle maximum.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 20, instruction address width.
- DATA_WIDTH, 16, instruction word width.
- MEM_DEPTH, 128, valid addresses are 0..MEM_DEPTH-1.
- LOCK_TIMEOUT, 16, idle cycles of the lock owner before forced release (>=1).

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  request to hold/keep the port after this transfer.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data, same packing.
- req_ready  out  NUM_REQ  one-hot or zero; transfer when valid&ready.
- instruction_wr  out  ADDR_WIDTH  memory write address (registered).
- instruction_wr_data  out  DATA_WIDTH  memory write data (registered).
- instruction_wr_enable  out  1  one-cycle write strobe (registered).
- grant_id  out  clog2(NUM_REQ)  requester of the last accepted transfer.
- locked  out  1  high while in LOCKED state.
- addr_error  out  1  one-cycle pulse: accepted request with out-of-range address.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; rr pointer=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0; idle counter 0.
  - Reset mid-burst drops the lock and any pending registered write.
- req_ready is combinational from req_valid, state and pointer. It never depends on req_lock of non-owners.
- IDLE/ARB state: ready goes to the first valid requester searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - On transfer, pointer ← granted index and grant_id ← index.
  - If req_lock[idx]=1 on that transfer, go to LOCKED with owner=idx.
- LOCKED state: only the owner can receive ready, and only when req_valid[owner]=1. Other requesters stall.
  - Owner transfer with req_lock=1: stay LOCKED, idle counter cleared.
  - Owner transfer with req_lock=0: go to ARB. The owner is last in the next round-robin order.
  - Owner req_valid=0 and req_lock=0: release to ARB next cycle, no pulse.
  - Owner req_valid=0 and req_lock=1: idle counter increments. When it reaches LOCK_TIMEOUT, pulse lock_timeout and go to ARB.
- Write output:
  - The cycle after a transfer, instruction_wr_enable=1 with the captured addr/data.
  - Otherwise enable=0; addr/data hold their last values.
  - Back-to-back transfers give back-to-back strobes, so throughput is 1 write/cycle.
- Address check:
  - Address >= MEM_DEPTH is still accepted (ready asserted), but the write is suppressed (enable=0).
  - addr_error pulses in the cycle the write would have appeared.
  - Lock semantics are unaffected.
- Width rules: addresses and data pass through unmodified. The pointer and owner wrap modulo NUM_REQ.
- Simultaneous events: an owner transfer in the same cycle the counter would expire counts as a transfer (no timeout).

Optional Feature:
- Macro INSTRUCTION_WRITE_ARBITER_STATS_EN.
- When defined, adds output write_count (32 bits) and input stats_clear (1 bit).
  - write_count increments on every strobed write; suppressed address-error writes are not counted.
  - It saturates at all-ones.
  - stats_clear zeroes it synchronously; clear takes precedence over increment in the same cycle.
  - Reset sets it to 0.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Single requester: req_valid[2]=1, addr=0x00005, data=0xBEEF for one cycle → req_ready=0100 that cycle. Next cycle: instruction_wr=5, instruction_wr_data=0xBEEF, enable=1, grant_id=2.
- Fairness: all four valid continuously for 8 cycles after reset → grants in order 0,1,2,3,0,1,2,3, with 8 consecutive enable strobes.
- Lock burst: requester 1 sends 3 transfers with lock=1,1,0 while 0 and 3 are valid → ready only to 1 for those cycles. Next grant goes to 3, because the pointer was at 1; then 0.
- Lock timeout: LOCK_TIMEOUT=4; requester 0 locks, then holds valid=0, lock=1 while requester 2 is valid → lock_timeout pulses 4 cycles after the last transfer; requester 2 is granted the following cycle.
- Address error: addr=128 with MEM_DEPTH=128 → transfer accepted, enable stays 0, addr_error=1 for one cycle. With the stats macro, write_count is unchanged.
- Reset mid-lock: drive reset=0 asynchronously while LOCKED with a write pending → enable, locked and req_ready go 0 immediately. After release, requester 0 is first in round-robin order.

Source files
------------

// File: rtl/instruction_write_arbiter.sv
// Round-robin arbiter sharing one instruction-memory write port, with burst lock and lock timeout; optional stats via INSTRUCTION_WRITE_ARBITER_STATS_EN.
// Latency: write strobe, addr_error and grant_id are registered, one cycle after the valid&ready transfer.
// Backpressure: req_ready is combinational and one-hot; non-owners stall while the port is locked.
module instruction_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_DEPTH    = 128,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [ADDR_WIDTH-1:0]            instruction_wr,
  output logic [DATA_WIDTH-1:0]            instruction_wr_data,
  output logic                             instruction_wr_enable,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             locked,
  output logic                             addr_error,
  output logic                             lock_timeout
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
  ,
  input  logic                             stats_clear,
  output logic [31:0]                      write_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, owner, owner_d;
  logic [CW-1:0]   idle_cnt, idle_cnt_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic           arb_vld, sel_vld, xfer, sel_lock, addr_ok;
  logic [IDW-1:0] arb_idx, sel_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  int             j;

  // Walk downward so the requester closest after the pointer is the last (winning) assignment.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    j       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[j]) begin
        arb_vld = 1'b1;
        arb_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = arb_idx;
    if (state == ST_LOCKED) begin
      sel_idx = owner;
      sel_vld = req_valid[owner];
    end else begin
      sel_vld = arb_vld;
    end
  end

  assign xfer      = sel_vld & reset;
  assign req_ready = xfer ? (NUM_REQ'(1) << sel_idx) : '0;
  assign sel_lock  = req_lock[sel_idx];
  assign sel_addr  = addr_arr[sel_idx];
  assign sel_data  = data_arr[sel_idx];
  assign addr_ok   = ({1'b0, sel_addr} < DEPTH_W);

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    idle_cnt_d   = idle_cnt;
    lock_timeout = 1'b0;
    case (state)
      ST_ARB: begin
        if (xfer && sel_lock) begin
          state_d    = ST_LOCKED;
          owner_d    = sel_idx;
          idle_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (!sel_lock) state_d = ST_ARB;
        end else if (!req_lock[owner]) begin
          state_d    = ST_ARB;
          idle_cnt_d = '0;
        end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          // This idle cycle is the LOCK_TIMEOUT-th one: release now.
          lock_timeout = 1'b1;
          state_d      = ST_ARB;
          idle_cnt_d   = '0;
        end else begin
          idle_cnt_d = idle_cnt + CW'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= ST_ARB;
      ptr                   <= IDW'(NUM_REQ - 1);
      owner                 <= '0;
      idle_cnt              <= '0;
      instruction_wr_enable <= 1'b0;
      instruction_wr        <= '0;
      instruction_wr_data   <= '0;
      grant_id              <= '0;
      addr_error            <= 1'b0;
    end else begin
      state                 <= state_d;
      owner                 <= owner_d;
      idle_cnt              <= idle_cnt_d;
      instruction_wr_enable <= 1'b0;
      addr_error            <= 1'b0;
      if (xfer) begin
        ptr      <= sel_idx;
        grant_id <= sel_idx;
        if (addr_ok) begin
          instruction_wr_enable <= 1'b1;
          instruction_wr        <= sel_addr;
          instruction_wr_data   <= sel_data;
        end else begin
          addr_error <= 1'b1;
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_count <= '0;
    end else if (stats_clear) begin
      write_count <= '0;
    end else if (xfer && addr_ok && (write_count != 32'hFFFF_FFFF)) begin
      write_count <= write_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_write_arbiter.sv
// Directed bench for instruction_write_arbiter: single write, fairness, lock burst, timeout, address error, reset mid-lock.
module tb_instruction_write_arbiter;
  localparam int NR = 4;
  localparam int AW = 20;
  localparam int DW = 16;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_lock;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [AW-1:0]     instruction_wr;
  logic [DW-1:0]     instruction_wr_data;
  logic              instruction_wr_enable;
  logic [1:0]        grant_id;
  logic              locked;
  logic              addr_error;
  logic              lock_timeout;
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
  logic              stats_clear;
  logic [31:0]       write_count;
  logic [31:0]       wc_before;
`endif

  int total = 0;
  int bad   = 0;

  instruction_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(128), .LOCK_TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .instruction_wr(instruction_wr), .instruction_wr_data(instruction_wr_data),
    .instruction_wr_enable(instruction_wr_enable),
    .grant_id(grant_id), .locked(locked), .addr_error(addr_error), .lock_timeout(lock_timeout)
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
    , .stats_clear(stats_clear), .write_count(write_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_lock[i]           = l;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    tick();
    check("rst_en",    32'(instruction_wr_enable), 32'd0);
    check("rst_wr",    32'(instruction_wr), 32'd0);
    check("rst_gid",   32'(grant_id), 32'd0);
    check("rst_lock",  32'(locked), 32'd0);
    check("rst_aerr",  32'(addr_error), 32'd0);
    check("rst_lto",   32'(lock_timeout), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("rst_rdy_held", 32'(req_ready), 32'd0);
    req_valid = '0;
    reset = 1'b1;
    #1;

    // Single requester
    set_req(2, 1'b1, 1'b0, 20'h00005, 16'hBEEF);
    #1;
    check("single_rdy", 32'(req_ready), 32'b0100);
    tick();
    set_req(2, 1'b0, 1'b0, 20'h0, 16'h0);
    check("single_en",   32'(instruction_wr_enable), 32'd1);
    check("single_wr",   32'(instruction_wr), 32'h5);
    check("single_dat",  32'(instruction_wr_data), 32'hBEEF);
    check("single_gid",  32'(grant_id), 32'd2);
    tick();
    check("single_en_off", 32'(instruction_wr_enable), 32'd0);
    check("single_wr_hold", 32'(instruction_wr), 32'h5);

    // Fairness from reset
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(32'h10 + i), DW'(32'hA000 + i));
    for (int n = 0; n < 8; n++) begin
      #1;
      check("fair_rdy", 32'(req_ready), 32'(1) << (n % 4));
      tick();
      check("fair_en",  32'(instruction_wr_enable), 32'd1);
      check("fair_gid", 32'(grant_id), 32'(n % 4));
      check("fair_dat", 32'(instruction_wr_data), 32'hA000 + 32'(n % 4));
    end
    clear_reqs();
    tick();
    check("fair_en_off", 32'(instruction_wr_enable), 32'd0);

    // Lock burst: bring pointer to 0 first
    do_reset();
    set_req(0, 1'b1, 1'b0, 20'h30, 16'h3000);
    #1;
    check("lk_pre_rdy", 32'(req_ready), 32'b0001);
    tick();
    set_req(0, 1'b1, 1'b0, 20'h40, 16'h4000);
    set_req(1, 1'b1, 1'b1, 20'h41, 16'h4001);
    set_req(3, 1'b1, 1'b0, 20'h43, 16'h4003);
    #1;
    check("lk_rdy1", 32'(req_ready), 32'b0010);
    tick();
    check("lk_locked1", 32'(locked), 32'd1);
    check("lk_wr1", 32'(instruction_wr), 32'h41);
    check("lk_rdy2", 32'(req_ready), 32'b0010);
    tick();
    check("lk_locked2", 32'(locked), 32'd1);
    req_lock[1] = 1'b0;
    #1;
    check("lk_rdy3", 32'(req_ready), 32'b0010);
    tick();
    check("lk_unlocked", 32'(locked), 32'd0);
    check("lk_gid3", 32'(grant_id), 32'd1);
    req_valid[1] = 1'b0;
    #1;
    check("lk_next_rdy", 32'(req_ready), 32'b1000);
    tick();
    check("lk_next_gid", 32'(grant_id), 32'd3);
    req_valid[3] = 1'b0;
    #1;
    check("lk_then_rdy", 32'(req_ready), 32'b0001);
    tick();
    check("lk_then_gid", 32'(grant_id), 32'd0);
    clear_reqs();

    // Lock timeout (LOCK_TIMEOUT=4)
    do_reset();
    set_req(0, 1'b1, 1'b1, 20'h50, 16'h5000);
    set_req(2, 1'b1, 1'b0, 20'h52, 16'h5002);
    #1;
    check("to_rdy0", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("to_wait_lto", 32'(lock_timeout), 32'd0);
      check("to_wait_rdy", 32'(req_ready), 32'd0);
      tick();
    end
    check("to_pulse", 32'(lock_timeout), 32'd1);
    check("to_pulse_rdy", 32'(req_ready), 32'd0);
    tick();
    check("to_pulse_off", 32'(lock_timeout), 32'd0);
    check("to_unlocked", 32'(locked), 32'd0);
    check("to_rdy2", 32'(req_ready), 32'b0100);
    tick();
    check("to_gid2", 32'(grant_id), 32'd2);
    check("to_en2", 32'(instruction_wr_enable), 32'd1);
    clear_reqs();

    // Address error
    do_reset();
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
    wc_before = write_count;
`endif
    set_req(1, 1'b1, 1'b0, 20'd128, 16'h1234);
    #1;
    check("ae_rdy", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 1'b0, 20'd0, 16'h0);
    check("ae_en", 32'(instruction_wr_enable), 32'd0);
    check("ae_pulse", 32'(addr_error), 32'd1);
    check("ae_gid", 32'(grant_id), 32'd1);
    check("ae_wr_hold", 32'(instruction_wr), 32'd0);
`ifdef INSTRUCTION_WRITE_ARBITER_STATS_EN
    check("ae_wcount", write_count, wc_before);
`endif
    tick();
    check("ae_pulse_off", 32'(addr_error), 32'd0);

    // Reset mid-lock with pending write
    do_reset();
    set_req(0, 1'b1, 1'b1, 20'h60, 16'h6000);
    set_req(3, 1'b1, 1'b0, 20'h63, 16'h6003);
    tick();
    check("rl_en_pre", 32'(instruction_wr_enable), 32'd1);
    check("rl_locked_pre", 32'(locked), 32'd1);
    check("rl_rdy_pre", 32'(req_ready), 32'b0001);
    #1;
    reset = 1'b0;
    #1;
    check("rl_en", 32'(instruction_wr_enable), 32'd0);
    check("rl_locked", 32'(locked), 32'd0);
    check("rl_rdy", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rl_rr_first", 32'(req_ready), 32'b0001);
    clear_reqs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
